program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, SHALL set the largest legal program length in 32-bit words (legal range 1..MAX_WORDS).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first loaded instruction word.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port byteIn, input, 8 bits: streamed program byte.
REQ-006 Port byteValid, input, 1 bit: byteIn holds a valid byte.
REQ-007 Port byteReady, output, 1 bit: loader accepts a byte; a transfer occurs on a rising edge where byteValid and byteReady are both 1.
REQ-008 Port memWe, output, 1 bit: one-cycle write strobe to the instruction memory write port.
REQ-009 Port memAddr, output, 32 bits: byte address of the word being written.
REQ-010 Port memDIn, output, 32 bits: instruction word to write.
REQ-011 Port cpuRun, output, 1 bit: 1 releases the CPU; 0 holds it.
REQ-012 Port loadErr, output, 1 bit: a load failed; sticky until reset.
REQ-013 Port wordCount, output, 32 bits: number of instruction words written so far.

Function
REQ-014 The input stream SHALL be: one header word N, then N data words, then one checksum word; each word is 4 bytes, first byte = bits [31:24] (big-endian).
REQ-015 The FSM SHALL have the states HDR, DATA, WR, CSUM, RUN and ERR.
REQ-016 In HDR, DATA and CSUM, byteReady SHALL be 1; in WR, RUN and ERR, it SHALL be 0.
REQ-017 A 2-bit byte counter SHALL shift accepted bytes into a 32-bit assembly register and wrap from 3 to 0 on the 4th accepted byte.
REQ-018 HDR: on the 4th byte, if the assembled N is 0 or N > MAX_WORDS, the FSM SHALL go to ERR; otherwise it SHALL latch N and go to DATA.
REQ-019 DATA: on the 4th byte, the FSM SHALL go to WR.
REQ-020 WR (exactly 1 cycle): memWe=1, memDIn=assembled word, memAddr=BASE_ADDR+4*wordCount.
REQ-021 On exit from WR, wordCount SHALL increment, the checksum accumulator SHALL add the word mod 2^32, and the FSM SHALL go to CSUM if wordCount (new) == N, else to DATA.
REQ-022 CSUM: on the 4th byte, the FSM SHALL go to RUN if the assembled word equals the accumulator, else to ERR.
REQ-023 Header and checksum words SHALL NOT be added to the accumulator.
REQ-024 RUN: cpuRun=1 and loadErr=0; RUN is terminal until reset, and byteValid SHALL be ignored.
REQ-025 ERR: loadErr=1 and cpuRun=0; ERR is terminal until reset.
REQ-026 memWe SHALL be 0 in every state except WR.
REQ-027 memAddr and memDIn are don't-care when memWe=0 but SHALL hold their last values (no X).
REQ-028 Latency: the first memWe SHALL occur exactly 1 cycle after the 8th accepted byte.
REQ-029 A minimum load SHALL take 4*(N+2)+N cycles with byteValid held at 1.
REQ-030 byteValid low mid-word SHALL stall the byte counter with no loss of partial bytes; there is no timeout.

Reset
REQ-031 When reset=1, the block SHALL go to HDR and set byte counter=0, accumulator=0, wordCount=0, memWe=0, cpuRun=0, loadErr=0, memAddr=0 and memDIn=0; byteReady=1 from the first cycle after reset deasserts.
REQ-032 Reset asserted mid-load, in RUN or in ERR SHALL discard partial bytes and restart at HDR; words already written to memory are not rewritten.
REQ-033 Reset asserted in the same cycle as a byte handshake SHALL take priority, and the byte SHALL be dropped.

Verification
REQ-034 Load N=2, words 32'h2008_0005 and 32'h0000_000C, checksum 32'h2008_0011, with byteValid held at 1 -> memWe at addr 0 then 4 with those data; cpuRun=1 after the last checksum byte; wordCount=2; loadErr=0.
REQ-035 Header N=0, and separately N=MAX_WORDS+1 -> ERR after the 4th byte; loadErr=1; no memWe; cpuRun=0; byteReady=0.
REQ-036 Same stream as REQ-034 with checksum 32'h2008_0012 -> 2 writes occur, then loadErr=1 and cpuRun stays 0.
REQ-037 Same stream as REQ-034 with byteValid toggling 1/0 randomly -> identical memory writes and final state; byteReady=0 during each WR cycle.
REQ-038 Reset pulsed after 2 bytes of data word 2 -> state HDR and wordCount=0; a fresh complete load of N=1, word 32'hDEAD_BEEF, checksum 32'hDEAD_BEEF -> write at addr 0 and cpuRun=1.
REQ-039 N=MAX_WORDS load -> last write at BASE_ADDR+4*(MAX_WORDS-1); accumulator wraps mod 2^32 correctly; RUN reached.

Source files
------------

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time program loader. A byte stream arrives over a valid/ready
// handshake and is unpacked into 32-bit big-endian words. The stream consists
// of a header word N (number of instruction words), N instruction words and a
// trailing checksum word. Each instruction word is written into instruction
// memory through a one-cycle write strobe. The checksum is the modulo-2^32
// sum of the instruction words only. On a checksum match the CPU is released
// (cpuRun). A bad header or a bad checksum latches loadErr instead. Both
// outcomes are terminal until reset.
//
// Parameters
//   MAX_WORDS  largest legal program length in words (legal N is 1..MAX_WORDS)
//   BASE_ADDR  byte address that receives the first instruction word
//
// Ports
//   clk        single clock, everything updates on its rising edge
//   reset      synchronous, active-high reset
//   byteIn     streamed program byte
//   byteValid  byteIn carries a valid byte
//   byteReady  loader can accept a byte this cycle
//   memWe      one-cycle write strobe to the instruction memory
//   memAddr    byte address of the word being written
//   memDIn     instruction word being written
//   cpuRun     1 releases the CPU, 0 holds it
//   loadErr    sticky load failure flag
//   wordCount  number of instruction words written so far
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic        byteReady,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memDIn,
    output logic        cpuRun,
    output logic        loadErr,
    output logic [31:0] wordCount
);

    // Loader phases. WR is the single write cycle between data words. RUN and
    // ERR are the two terminal outcomes.
    typedef enum logic [2:0] {
        HDR,
        DATA,
        WR,
        CSUM,
        RUN,
        ERR
    } stateT;

    localparam logic [31:0] MAX_WORDS_VEC = 32'(MAX_WORDS);

    stateT       state;
    logic [1:0]  byteCount;
    logic [31:0] asmReg;
    logic [31:0] numWords;
    logic [31:0] checksumAcc;

    logic        handshake;
    logic        lastByte;
    logic [31:0] nextWord;
    logic [31:0] nextCount;
    logic [31:0] nextAddr;
    logic        headerBad;

    // A byte moves only when both sides agree. byteReady is a registered
    // state decode, so it is already low in WR/RUN/ERR. A handshake therefore
    // can only happen in HDR, DATA or CSUM.
    assign handshake = byteValid && byteReady;

    // The 4th byte of a word is the one that arrives while the counter sits
    // at 3.
    assign lastByte = (byteCount == 2'd3);

    // The word as it will look once the current byte is shifted in. Earlier
    // bytes move up, so the first byte received ends up in bits [31:24].
    assign nextWord = (asmReg << 8) | {24'd0, byteIn};

    // Word count and write address used by the WR cycle.
    assign nextCount = wordCount + 32'd1;
    assign nextAddr  = BASE_ADDR + (wordCount << 2);

    // A header of zero words, or more words than the memory region holds, is
    // rejected before anything is written.
    assign headerBad = (nextWord == 32'd0) || (nextWord > MAX_WORDS_VEC);

    // The whole loader is one registered FSM. Every output is a register that
    // is set on the same edge as the state change it belongs to. This keeps
    // byteReady, memWe, cpuRun and loadErr exactly aligned with the state
    // encoding and free of combinational glitches.
    //
    // Reset wins over a simultaneous handshake, so a byte presented during
    // reset is dropped and partial words are discarded. Memory contents
    // are not touched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HDR;
            byteCount   <= 2'd0;
            asmReg      <= 32'd0;
            numWords    <= 32'd0;
            checksumAcc <= 32'd0;
            wordCount   <= 32'd0;
            byteReady   <= 1'b1;
            memWe       <= 1'b0;
            memAddr     <= 32'd0;
            memDIn      <= 32'd0;
            cpuRun      <= 1'b0;
            loadErr     <= 1'b0;
        end else begin
            memWe <= 1'b0;

            // Byte assembly is common to all three receiving states. A stall
            // (byteValid low) simply leaves the counter and partial word alone.
            if (handshake) begin
                asmReg    <= nextWord;
                byteCount <= byteCount + 2'd1;
            end

            case (state)
                HDR: begin
                    if (handshake && lastByte) begin
                        if (headerBad) begin
                            state     <= ERR;
                            byteReady <= 1'b0;
                            loadErr   <= 1'b1;
                        end else begin
                            numWords <= nextWord;
                            state    <= DATA;
                        end
                    end
                end

                DATA: begin
                    // The write is launched on the same edge that completes
                    // the word. memWe is then high for exactly the WR cycle.
                    if (handshake && lastByte) begin
                        state     <= WR;
                        byteReady <= 1'b0;
                        memWe     <= 1'b1;
                        memDIn    <= nextWord;
                        memAddr   <= nextAddr;
                    end
                end

                WR: begin
                    // memDIn still holds the word just written. It feeds the
                    // checksum so that the header and checksum words never do.
                    wordCount   <= nextCount;
                    checksumAcc <= checksumAcc + memDIn;
                    byteReady   <= 1'b1;
                    if (nextCount == numWords) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA;
                    end
                end

                CSUM: begin
                    if (handshake && lastByte) begin
                        byteReady <= 1'b0;
                        if (nextWord == checksumAcc) begin
                            state  <= RUN;
                            cpuRun <= 1'b1;
                        end else begin
                            state   <= ERR;
                            loadErr <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    // Terminal: the CPU owns the machine until the next reset.
                    state     <= RUN;
                    byteReady <= 1'b0;
                    cpuRun    <= 1'b1;
                    loadErr   <= 1'b0;
                end

                ERR: begin
                    // Terminal: the CPU stays held until the next reset.
                    state     <= ERR;
                    byteReady <= 1'b0;
                    cpuRun    <= 1'b0;
                    loadErr   <= 1'b1;
                end

                default: begin
                    // Unreachable encodings fail safe and keep the CPU held.
                    state     <= ERR;
                    byteReady <= 1'b0;
                    cpuRun    <= 1'b0;
                    loadErr   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Streams are built as a list of
// instruction words plus header and checksum. Expected results come from a
// simple model:
//   - a header N is legal when 1 <= N <= MAX_WORDS;
//   - a legal header yields N writes of word i at BASE + 4*i;
//   - the CPU runs when the checksum equals the 32-bit sum of the words.
// A negedge monitor records every memory write and the cycle it happened in.
// ---------------------------------------------------------------------------
module tb_program_loader;

    localparam int unsigned MAXW = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memDIn;
    logic        cpuRun;
    logic        loadErr;
    logic [31:0] wordCount;

    program_loader #(
        .MAX_WORDS(MAXW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .byteIn(byteIn),
        .byteValid(byteValid),
        .byteReady(byteReady),
        .memWe(memWe),
        .memAddr(memAddr),
        .memDIn(memDIn),
        .cpuRun(cpuRun),
        .loadErr(loadErr),
        .wordCount(wordCount)
    );

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int readyDuringWr = 0;

    logic [31:0] txWords[$];
    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          wrCycleQ[$];
    int          hsCycleQ[$];

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter, used to time handshakes and writes
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Write monitor: memWe lasts one full cycle, so exactly one negedge sees it
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            wrAddrQ.push_back(memAddr);
            wrDataQ.push_back(memDIn);
            wrCycleQ.push_back(cycleCnt);
            if (byteReady !== 1'b0) readyDuringWr++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offer one byte, with byteValid randomly gapped, until it is accepted
    task automatic sendByte(input logic [7:0] b, input int validPct);
        bit accepted;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < validPct) begin
                byteValid = 1'b1;
                byteIn    = b;
                if (byteReady === 1'b1) begin
                    accepted = 1'b1;
                    hsCycleQ.push_back(cycleCnt + 1);
                end
            end else begin
                byteValid = 1'b0;
                byteIn    = 8'($urandom);
            end
        end
        if (!accepted) checkOutput("byteAccepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic sendWord(input logic [31:0] w, input int validPct);
        for (int k = 3; k >= 0; k--) sendByte(w[k*8 +: 8], validPct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            byteValid = 1'b0;
            byteIn    = 8'd0;
        end
    endtask

    // One reset edge; optionally offer a byte in that cycle so it must be dropped
    task automatic doReset(input bit withByte);
        @(negedge clk);
        reset     = 1'b1;
        byteValid = withByte;
        byteIn    = 8'h5A;
        @(negedge clk);
        reset     = 1'b0;
        byteValid = 1'b0;
        byteIn    = 8'd0;
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycleQ.delete();
        hsCycleQ.delete();
    endtask

    // Full stream: header, then (if the header is legal) data and checksum
    task automatic applyStimulus(input logic [31:0] hdr, input logic [31:0] csum, input int validPct);
        sendWord(hdr, validPct);
        if (hdr != 32'd0 && hdr <= MAXW) begin
            foreach (txWords[i]) sendWord(txWords[i], validPct);
            sendWord(csum, validPct);
        end
        idle(2);
    endtask

    function automatic logic [31:0] modelSum();
        logic [31:0] s;
        s = 32'd0;
        foreach (txWords[i]) s = s + txWords[i];
        return s;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".byteReady"}, {31'd0, byteReady}, 32'd1);
        checkOutput({tag, ".memWe"}, {31'd0, memWe}, 32'd0);
        checkOutput({tag, ".memAddr"}, memAddr, 32'd0);
        checkOutput({tag, ".memDIn"}, memDIn, 32'd0);
        checkOutput({tag, ".cpuRun"}, {31'd0, cpuRun}, 32'd0);
        checkOutput({tag, ".loadErr"}, {31'd0, loadErr}, 32'd0);
        checkOutput({tag, ".wordCount"}, wordCount, 32'd0);
    endtask

    // Compare recorded writes and final flags against the stream model
    task automatic checkLoad(input string tag, input logic [31:0] hdr, input logic [31:0] csum);
        bit hdrOk;
        bit expRun;
        int expWrites;
        hdrOk     = (hdr != 32'd0) && (hdr <= MAXW);
        expWrites = hdrOk ? int'(hdr) : 0;
        expRun    = hdrOk && (csum == modelSum());
        checkOutput({tag, ".writes"}, wrAddrQ.size(), expWrites);
        for (int i = 0; i < expWrites && i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("%s.addr%0d", tag, i), wrAddrQ[i], BASE + 32'(4 * i));
            checkOutput($sformatf("%s.data%0d", tag, i), wrDataQ[i], txWords[i]);
        end
        checkOutput({tag, ".cpuRun"}, {31'd0, cpuRun}, {31'd0, expRun});
        checkOutput({tag, ".loadErr"}, {31'd0, loadErr}, {31'd0, !expRun});
        checkOutput({tag, ".wordCount"}, wordCount, 32'(expWrites));
        checkOutput({tag, ".byteReady"}, {31'd0, byteReady}, 32'd0);
    endtask

    // Back-to-back stream: first write in the cycle right after the 8th
    // handshake edge, and the whole load spans 4*(N+2)+N edges
    task automatic checkTiming(input string tag, input int n);
        if (hsCycleQ.size() >= 8 && wrCycleQ.size() >= 1)
            checkOutput({tag, ".firstWe"}, wrCycleQ[0], hsCycleQ[7]);
        if (hsCycleQ.size() >= 1)
            checkOutput({tag, ".loadCycles"}, hsCycleQ[hsCycleQ.size()-1] - hsCycleQ[0] + 1, 4 * (n + 2) + n);
    endtask

    initial begin
        int n;
        int pct;
        int rdBefore;
        logic [31:0] csum;
        logic [31:0] sum;

        reset     = 1'b1;
        byteValid = 1'b0;
        byteIn    = 8'd0;

        $display("[TB] reset state");
        doReset(1'b0);
        checkResetState("reset0");

        $display("[TB] basic load, byteValid held high");
        txWords = '{32'h2008_0005, 32'h0000_000C};
        applyStimulus(32'd2, 32'h2008_0011, 100);
        checkLoad("basic", 32'd2, 32'h2008_0011);
        checkTiming("basic", 2);

        $display("[TB] RUN ignores byteValid");
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycleQ.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            byteValid = 1'b1;
            byteIn    = 8'($urandom);
        end
        idle(1);
        checkOutput("runIgnore.writes", wrAddrQ.size(), 0);
        checkOutput("runIgnore.cpuRun", {31'd0, cpuRun}, 32'd1);
        checkOutput("runIgnore.wordCount", wordCount, 32'd2);

        $display("[TB] bad checksum");
        doReset(1'b0);
        checkResetState("resetFromRun");
        applyStimulus(32'd2, 32'h2008_0012, 100);
        checkLoad("badCsum", 32'd2, 32'h2008_0012);

        $display("[TB] illegal headers");
        doReset(1'b0);
        checkResetState("resetFromErr");
        txWords.delete();
        applyStimulus(32'd0, 32'd0, 100);
        checkLoad("hdrZero", 32'd0, 32'd0);
        doReset(1'b0);
        applyStimulus(32'(MAXW + 1), 32'd0, 100);
        checkLoad("hdrTooBig", 32'(MAXW + 1), 32'd0);

        $display("[TB] random byteValid gaps");
        doReset(1'b0);
        txWords  = '{32'h2008_0005, 32'h0000_000C};
        rdBefore = readyDuringWr;
        applyStimulus(32'd2, 32'h2008_0011, 50);
        checkLoad("gapped", 32'd2, 32'h2008_0011);
        checkOutput("gapped.readyInWr", 32'(readyDuringWr - rdBefore), 32'd0);

        $display("[TB] reset mid-load with a byte offered");
        doReset(1'b0);
        sendWord(32'd2, 100);
        sendWord(32'h2008_0005, 100);
        sendByte(8'h00, 100);
        sendByte(8'h00, 100);
        checkOutput("midReset.writesBefore", wrAddrQ.size(), 1);
        doReset(1'b1);
        checkResetState("midReset");
        txWords = '{32'hDEAD_BEEF};
        applyStimulus(32'd1, 32'hDEAD_BEEF, 100);
        checkLoad("afterMidReset", 32'd1, 32'hDEAD_BEEF);
        checkTiming("afterMidReset", 1);

        $display("[TB] randomized loads");
        for (int t = 0; t < 6; t++) begin
            doReset(1'b0);
            n = (t == 0) ? int'(MAXW) : int'($urandom_range(MAXW, 1));
            txWords.delete();
            for (int i = 0; i < n; i++)
                txWords.push_back((t == 0) ? (32'hFFFF_FF00 + 32'(i * 7)) : $urandom);
            sum  = modelSum();
            csum = (t % 3 == 2) ? sum + 32'($urandom_range(1000, 1)) : sum;
            pct  = (t == 0) ? 100 : int'($urandom_range(100, 25));
            applyStimulus(32'(n), csum, pct);
            checkLoad($sformatf("rand%0d", t), 32'(n), csum);
            if (pct == 100) checkTiming($sformatf("rand%0d", t), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
